// File: rtl/bnn_pkg.sv
// Shared definitions for the BNN command sequencer.
//   - Opcode byte values understood by the sequencer.
//   - seq_state_t : sequencer FSM states.
//   - wr_tgt_t    : buffer selected by the latest write opcode.
//   - tgt_onehot  : maps a target to its one-hot write-select pattern.
package bnn_pkg;

  localparam logic [7:0] OP_NOP   = 8'h00;
  localparam logic [7:0] OP_WR_IN = 8'hB1;
  localparam logic [7:0] OP_WR_W  = 8'hB2;
  localparam logic [7:0] OP_WR_B  = 8'hB3;
  localparam logic [7:0] OP_RUN   = 8'hAE;

  typedef enum logic [1:0] {IDLE, LOAD, RUN} seq_state_t;

  typedef enum logic [1:0] {TGT_IN, TGT_W, TGT_B} wr_tgt_t;

  // Bit order matches wr_sel: [0] inputs, [1] weights, [2] bias.
  function automatic logic [2:0] tgt_onehot(input wr_tgt_t tgt);
    logic [2:0] sel;
    unique case (tgt)
      TGT_IN:  sel = 3'b001;
      TGT_W:   sel = 3'b010;
      TGT_B:   sel = 3'b100;
      default: sel = 3'b000;
    endcase
    return sel;
  endfunction

endpackage

// File: rtl/bnn_payload_counter.sv
// Payload length / address counter for the command sequencer.
// Ports:
//   clk, rst_n  : clock, asynchronous active-low reset
//   load, len   : load a payload length; clears the address
//   step        : one payload byte consumed
//   remaining   : bytes still expected in the current payload
//   wr_addr     : index of the next payload byte, starting at 0
//   last        : the next consumed byte is the final one
module bnn_payload_counter
  import bnn_pkg::*;
#(
  parameter int unsigned ADDR_W = 10
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load,
  input  logic [ADDR_W:0]   len,
  input  logic              step,
  output logic [ADDR_W:0]   remaining,
  output logic [ADDR_W-1:0] wr_addr,
  output logic              last
);

  logic [ADDR_W:0]   rem_q, rem_d;
  logic [ADDR_W-1:0] addr_q, addr_d;

  assign last = (rem_q == {{ADDR_W{1'b0}}, 1'b1});

  always_comb begin
    rem_d  = rem_q;
    addr_d = addr_q;
    if (load) begin
      rem_d  = len;
      addr_d = '0;
    end else if (step && (rem_q != '0)) begin
      rem_d = rem_q - 1'b1;
      // Hold on the final byte so the address never exceeds length-1.
      if (!last) begin
        addr_d = addr_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rem_q  <= '0;
      addr_q <= '0;
    end else begin
      rem_q  <= rem_d;
      addr_q <= addr_d;
    end
  end

  assign remaining = rem_q;
  assign wr_addr   = addr_q;

endmodule

// File: rtl/bnn_cmd_sequencer.sv
// Byte-stream command sequencer between the SPI byte interface and the BNN
// buffers/core. Decodes opcodes, streams fixed-length payloads into the
// input/weight/bias buffers and launches/tracks inference runs.
// Ports:
//   byte_valid/byte_data/byte_ready : SPI byte handshake
//   wr_en/wr_sel/wr_addr/wr_data    : registered buffer write port
//   start, done                     : run launch pulse / core completion
//   mode                            : {run, bias, weight, input} state view
//   err                             : one-cycle pulse on an illegal opcode
module bnn_cmd_sequencer
  import bnn_pkg::*;
#(
  parameter int unsigned IN_BYTES = 98,
  parameter int unsigned W_BYTES  = 980,
  parameter int unsigned B_BYTES  = 10,
  parameter int unsigned ADDR_W   = 10
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              byte_valid,
  input  logic [7:0]        byte_data,
  output logic              byte_ready,
  output logic              wr_en,
  output logic [2:0]        wr_sel,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [7:0]        wr_data,
  output logic              start,
  input  logic              done,
  output logic [3:0]        mode,
  output logic              err
);

  localparam int unsigned CntW = ADDR_W + 1;
  localparam logic [ADDR_W:0] InLen = CntW'(IN_BYTES);
  localparam logic [ADDR_W:0] WLen  = CntW'(W_BYTES);
  localparam logic [ADDR_W:0] BLen  = CntW'(B_BYTES);

  seq_state_t        state_q, state_d;
  wr_tgt_t           tgt_q, tgt_d;
  logic              wr_en_q, wr_en_d;
  logic [2:0]        wr_sel_q, wr_sel_d;
  logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
  logic [7:0]        wr_data_q, wr_data_d;
  logic              start_q, start_d;
  logic              err_q, err_d;

  logic              cnt_load, cnt_step, cnt_last;
  logic [ADDR_W:0]   cnt_len, cnt_remaining;
  logic [ADDR_W-1:0] cnt_addr;
  logic              accept;

  bnn_payload_counter #(
    .ADDR_W (ADDR_W)
  ) u_payload_counter (
    .clk       (clk),
    .rst_n     (rst_n),
    .load      (cnt_load),
    .len       (cnt_len),
    .step      (cnt_step),
    .remaining (cnt_remaining),
    .wr_addr   (cnt_addr),
    .last      (cnt_last)
  );

  assign byte_ready = (state_q != RUN);
  assign accept     = byte_valid & byte_ready;

  always_comb begin
    state_d   = state_q;
    tgt_d     = tgt_q;
    cnt_load  = 1'b0;
    cnt_len   = '0;
    cnt_step  = 1'b0;
    wr_en_d   = 1'b0;
    wr_sel_d  = '0;
    wr_addr_d = '0;
    wr_data_d = '0;
    start_d   = 1'b0;
    err_d     = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (accept) begin
          case (byte_data)
            OP_WR_IN: begin
              tgt_d    = TGT_IN;
              cnt_load = 1'b1;
              cnt_len  = InLen;
              state_d  = LOAD;
            end
            OP_WR_W: begin
              tgt_d    = TGT_W;
              cnt_load = 1'b1;
              cnt_len  = WLen;
              state_d  = LOAD;
            end
            OP_WR_B: begin
              tgt_d    = TGT_B;
              cnt_load = 1'b1;
              cnt_len  = BLen;
              state_d  = LOAD;
            end
            OP_RUN: begin
              start_d = 1'b1;
              state_d = RUN;
            end
            OP_NOP:  ;
            default: err_d = 1'b1;
          endcase
        end
      end
      LOAD: begin
        // Empty counter cannot occur with legal lengths; recover to IDLE.
        if (cnt_remaining == '0) begin
          state_d = IDLE;
        end else if (accept) begin
          wr_en_d   = 1'b1;
          wr_sel_d  = tgt_onehot(tgt_q);
          wr_addr_d = cnt_addr;
          wr_data_d = byte_data;
          cnt_step  = 1'b1;
          if (cnt_last) begin
            state_d = IDLE;
          end
        end
      end
      RUN: begin
        if (done) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      tgt_q     <= TGT_IN;
      wr_en_q   <= 1'b0;
      wr_sel_q  <= '0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
      start_q   <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      tgt_q     <= tgt_d;
      wr_en_q   <= wr_en_d;
      wr_sel_q  <= wr_sel_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
      start_q   <= start_d;
      err_q     <= err_d;
    end
  end

  always_comb begin
    mode = 4'b0000;
    unique case (state_q)
      LOAD:    mode = {1'b0, tgt_onehot(tgt_q)};
      RUN:     mode = 4'b1000;
      default: mode = 4'b0000;
    endcase
  end

  assign wr_en   = wr_en_q;
  assign wr_sel  = wr_sel_q;
  assign wr_addr = wr_addr_q;
  assign wr_data = wr_data_q;
  assign start   = start_q;
  assign err     = err_q;

endmodule

// File: tb/tb_bnn_cmd_sequencer.sv
// Scoreboard bench for bnn_cmd_sequencer: the driver feeds bytes through a
// behavioural model that queues the expected write/start/err events, and a
// monitor pops and compares whenever the DUT shows one.
module tb_bnn_cmd_sequencer;

  localparam int IN_BYTES = 98;
  localparam int W_BYTES  = 980;
  localparam int B_BYTES  = 10;
  localparam int ADDR_W   = 10;

  logic              clk;
  logic              rst_n;
  logic              byte_valid;
  logic [7:0]        byte_data;
  logic              byte_ready;
  logic              wr_en;
  logic [2:0]        wr_sel;
  logic [ADDR_W-1:0] wr_addr;
  logic [7:0]        wr_data;
  logic              start;
  logic              done;
  logic [3:0]        mode;
  logic              err;

  bnn_cmd_sequencer #(
    .IN_BYTES (IN_BYTES),
    .W_BYTES  (W_BYTES),
    .B_BYTES  (B_BYTES),
    .ADDR_W   (ADDR_W)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .byte_valid (byte_valid),
    .byte_data  (byte_data),
    .byte_ready (byte_ready),
    .wr_en      (wr_en),
    .wr_sel     (wr_sel),
    .wr_addr    (wr_addr),
    .wr_data    (wr_data),
    .start      (start),
    .done       (done),
    .mode       (mode),
    .err        (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // kind bits: [0] write, [1] start, [2] err
  typedef struct {
    logic [2:0] kind;
    logic [2:0] sel;
    int         addr;
    logic [7:0] data;
    int         due;
  } ev_t;

  ev_t exp_q[$];
  int  checks = 0;
  int  errors = 0;

  // Model: 0 = idle, 1 = loading, 2 = running
  int  m_state = 0;
  int  m_tgt   = 0;
  int  m_rem   = 0;
  int  m_addr  = 0;
  int  m_cyc   = 0;
  bit  m_acc   = 0;
  bit  in_reset = 1;

  task automatic check(input string name, input longint got, input longint want);
    checks++;
    if (got != want) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, got, want, m_cyc);
    end
  endtask

  function automatic int exp_mode();
    if (m_state == 1) return 1 << m_tgt;
    if (m_state == 2) return 8;
    return 0;
  endfunction

  function automatic int payload_len(input int tgt);
    if (tgt == 0) return IN_BYTES;
    if (tgt == 1) return W_BYTES;
    return B_BYTES;
  endfunction

  task automatic push_ev(input logic [2:0] kind, input logic [2:0] sel, input int addr,
                         input logic [7:0] data);
    ev_t e;
    e.kind = kind;
    e.sel  = sel;
    e.addr = addr;
    e.data = data;
    e.due  = m_cyc;
    exp_q.push_back(e);
  endtask

  // Effect of one rising edge on the model.
  task automatic model_step(input bit v, input logic [7:0] d, input bit dn);
    m_cyc++;
    m_acc = 0;
    if (m_state == 2) begin
      if (dn) m_state = 0;
    end else if (v) begin
      m_acc = 1;
      if (m_state == 1) begin
        push_ev(3'b001, 3'(1 << m_tgt), m_addr, d);
        m_addr++;
        m_rem--;
        if (m_rem == 0) m_state = 0;
      end else begin
        case (d)
          8'hB1, 8'hB2, 8'hB3: begin
            m_tgt   = int'(d) - 8'hB1;
            m_rem   = payload_len(m_tgt);
            m_addr  = 0;
            m_state = 1;
          end
          8'hAE: begin
            push_ev(3'b010, 3'b000, 0, 8'h00);
            m_state = 2;
          end
          8'h00: ;
          default: push_ev(3'b100, 3'b000, 0, 8'h00);
        endcase
      end
    end
  endtask

  // Called at a falling edge; returns at the next falling edge.
  task automatic cycle(input bit v, input logic [7:0] d, input bit dn);
    byte_valid = v;
    byte_data  = d;
    done       = dn;
    check("byte_ready", byte_ready, (m_state != 2) ? 1 : 0);
    @(posedge clk);
    model_step(v, d, dn);
    @(negedge clk);
  endtask

  task automatic check_reset_outs();
    check("reset_outs", {wr_en, wr_sel, wr_addr, wr_data, start, err, mode}, 0);
    check("reset_byte_ready", byte_ready, 1);
  endtask

  task automatic reset_pulse(input int ncyc);
    byte_valid = 1'b0;
    done       = 1'b0;
    rst_n      = 1'b0;
    in_reset   = 1;
    m_state    = 0;
    m_rem      = 0;
    m_addr     = 0;
    check("pending_before_reset", exp_q.size(), 0);
    exp_q.delete();
    #1;
    check_reset_outs();
    for (int i = 0; i < ncyc; i++) begin
      @(posedge clk);
      m_cyc++;
      @(negedge clk);
      check_reset_outs();
    end
    rst_n    = 1'b1;
    in_reset = 0;
  endtask

  ev_t mon_got;
  ev_t mon_want;

  always @(negedge clk) begin
    if (rst_n && !in_reset) begin
      check("mode", mode, exp_mode());
      if (wr_en || start || err) begin
        mon_got.kind = {err, start, wr_en};
        mon_got.sel  = wr_en ? wr_sel : 3'b000;
        mon_got.addr = wr_en ? int'(wr_addr) : 0;
        mon_got.data = wr_en ? wr_data : 8'h00;
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_event: got kind %b sel %b addr %0d data %0h, expected none",
                   mon_got.kind, mon_got.sel, mon_got.addr, mon_got.data);
        end else begin
          mon_want = exp_q.pop_front();
          check("ev_kind", mon_got.kind, mon_want.kind);
          check("ev_cycle", m_cyc, mon_want.due);
          if (mon_want.kind == 3'b001) begin
            check("wr_sel", mon_got.sel, mon_want.sel);
            check("wr_addr", mon_got.addr, mon_want.addr);
            check("wr_data", mon_got.data, mon_want.data);
          end
        end
      end else if (exp_q.size() != 0 && exp_q[0].due <= m_cyc) begin
        checks++;
        errors++;
        $display("FAIL missing_event: got none, expected kind %b due cycle %0d",
                 exp_q[0].kind, exp_q[0].due);
        void'(exp_q.pop_front());
      end
    end
  end

  initial begin
    int   got_n;
    logic [7:0] ops[6];
    ops[0] = 8'h00; ops[1] = 8'hB3; ops[2] = 8'hAE;
    ops[3] = 8'h7F; ops[4] = 8'hB1; ops[5] = 8'hC4;
    rst_n      = 1'b0;
    byte_valid = 1'b0;
    byte_data  = 8'h00;
    done       = 1'b0;
    @(negedge clk);
    reset_pulse(2);

    // Write inputs with pattern i ^ 0x5A.
    cycle(1, 8'hB1, 0);
    for (int i = 0; i < IN_BYTES; i++) cycle(1, 8'(i) ^ 8'h5A, 1'($urandom_range(1)));
    for (int i = 0; i < 3; i++) cycle(0, 8'hB1, 1);

    // Opcode-valued payload, then a real run opcode.
    cycle(1, 8'hB3, 0);
    for (int i = 0; i < B_BYTES; i++) cycle(1, 8'hAE, 1);
    cycle(1, 8'hAE, 0);

    // Run handshake: byte held off for 20 cycles while done is low.
    for (int i = 0; i < 20; i++) cycle(1, 8'hB1, 0);
    cycle(1, 8'hB1, 1);
    cycle(1, 8'hB1, 0);
    for (int i = 0; i < IN_BYTES; i++) cycle(1, 8'($urandom), 0);

    // Illegal opcode then NOP.
    cycle(1, 8'h7F, 0);
    cycle(1, 8'h00, 0);
    cycle(0, 8'h00, 0);

    // Reset mid-load, then a complete weight load.
    cycle(1, 8'hB2, 0);
    for (int i = 0; i < 500; i++) cycle(1, 8'($urandom), 0);
    cycle(0, 8'h00, 0);
    reset_pulse(2);
    cycle(1, 8'hB2, 0);
    for (int i = 0; i < W_BYTES; i++) cycle(1, 8'($urandom), 0);

    // Throttled input stream.
    cycle(1, 8'hB1, 0);
    got_n = 0;
    for (int k = 0; k < 2000 && got_n < IN_BYTES; k++) begin
      cycle(1'($urandom_range(1)), 8'($urandom), 0);
      if (m_acc) got_n++;
    end
    check("throttled_count", got_n, IN_BYTES);

    // Random opcode mix with random done.
    for (int k = 0; k < 400; k++) begin
      logic [7:0] b;
      b = (m_state == 1) ? 8'($urandom) : ops[$urandom_range(5)];
      cycle(1'($urandom_range(1)), b, ($urandom_range(3) == 0));
    end
    for (int k = 0; k < 120 && m_state != 0; k++) cycle(1, 8'($urandom), 1);
    for (int i = 0; i < 4; i++) cycle(0, 8'h00, 0);

    check("final_state_idle", m_state, 0);
    check("leftover_events", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
